// File: rtl/vga_timing_pkg.sv
// Raster timing constants and pixel types shared by vga_sync_gen and bg_* generators.
// Provides default 640x480 geometry, derived sync windows, RGB2 colour type, range helper.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb2_t;

    // Inclusive unsigned window test on a raster coordinate.
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_out_reg.sv
// Pin-side output stage: blanks rgb outside the visible area and delays sync by one tick.
// Ports: clk, rst_n (sync, active-low), tick, active, rgb, hsync, vsync -> vga_rgb, vga_hsync, vga_vsync.
module vga_out_reg
    import vga_timing_pkg::*;
#(
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick,
    input  logic  active,
    input  rgb2_t rgb,
    input  logic  hsync,
    input  logic  vsync,
    output rgb2_t vga_rgb,
    output logic  vga_hsync,
    output logic  vga_vsync
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_rgb   <= '0;
            vga_hsync <= SYNC_NEG;
            vga_vsync <= SYNC_NEG;
        end else if (tick) begin
            vga_rgb   <= active ? rgb : '0;
            vga_hsync <= hsync;
            vga_vsync <= vsync;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: pixel divider, x/y counters, sync/active decode, strobes, frame count.
// Ports: clk, rst_n, timing_en, rgb_in -> pix_x, pix_y, video_active, hsync, vsync,
//        line_start, frame_start, frame_cnt, vga_rgb, vga_hsync, vga_vsync.
module vga_sync_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_NEG  = 1'b1,
    parameter int PIX_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timing_en,
    input  logic [5:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_cnt,
    output logic [5:0] vga_rgb,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    import vga_timing_pkg::*;

    localparam coord_t H_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Divider only ever needs one bit: PIX_DIV is 1 or 2.
    localparam logic DIV_LAST = (PIX_DIV > 1);

    logic       div_q;
    logic       tick;

    coord_t     x_q;
    coord_t     y_q;
    coord_t     x_d;
    coord_t     y_d;
    logic [9:0] fc_q;
    logic [9:0] fc_d;

    logic       act_q;
    logic       act_d;
    logic       hs_q;
    logic       hs_d;
    logic       vs_q;
    logic       vs_d;
    logic       ls_q;
    logic       fs_q;

    rgb2_t      rgb_pin;

    always_comb begin
        tick = timing_en && (div_q == DIV_LAST);
    end

    // Next raster position; holds whenever no tick is due.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fc_d = fc_q + 10'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decoding the next-state position lets the registered flags
    // switch in the same clock as the counters.
    always_comb begin
        act_d = (x_d < H_VIS) && (y_d < V_VIS);
        hs_d  = in_span(x_d, HS_LO, HS_HI) ^ SYNC_NEG;
        vs_d  = in_span(y_d, VS_LO, VS_HI) ^ SYNC_NEG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            act_q <= 1'b1;
            hs_q  <= SYNC_NEG;
            vs_q  <= SYNC_NEG;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            if (timing_en) begin
                div_q <= tick ? 1'b0 : div_q + 1'b1;
            end
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            act_q <= act_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= tick && (x_d == '0);
            fs_q  <= tick && (x_d == '0) && (y_d == '0);
        end
    end

    vga_out_reg #(
        .SYNC_NEG (SYNC_NEG)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .active    (act_q),
        .rgb       (rgb2_t'(rgb_in)),
        .hsync     (hs_q),
        .vsync     (vs_q),
        .vga_rgb   (rgb_pin),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync)
    );

    assign pix_x        = x_q;
    assign pix_y        = y_q;
    assign frame_cnt    = fc_q;
    assign video_active = act_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign vga_rgb      = rgb_pin;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default geometry, PIX_DIV=2, and a tiny 8x6 raster
// so frame wrap, frame_cnt rollover and the enable freeze fit in a short run.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_d, en_v, en_s;
    logic [5:0] rgb;

    logic [9:0] d_x, d_y, d_fc, v_x, v_y, v_fc, s_x, s_y, s_fc;
    logic       d_act, d_hs, d_vs, d_ls, d_fs, d_ohs, d_ovs;
    logic       v_act, v_hs, v_vs, v_ls, v_fs, v_ohs, v_ovs;
    logic       s_act, s_hs, s_vs, s_ls, s_fs, s_ohs, s_ovs;
    logic [5:0] d_rgb, v_rgb, s_rgb;

    int total = 0;
    int bad   = 0;
    int cur_k = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_def (
        .clk(clk), .rst_n(rst_n), .timing_en(en_d), .rgb_in(rgb),
        .pix_x(d_x), .pix_y(d_y), .video_active(d_act),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs),
        .frame_cnt(d_fc), .vga_rgb(d_rgb), .vga_hsync(d_ohs), .vga_vsync(d_ovs)
    );

    vga_sync_gen #(.PIX_DIV(2)) u_div (
        .clk(clk), .rst_n(rst_n), .timing_en(en_v), .rgb_in(rgb),
        .pix_x(v_x), .pix_y(v_y), .video_active(v_act),
        .hsync(v_hs), .vsync(v_vs), .line_start(v_ls), .frame_start(v_fs),
        .frame_cnt(v_fc), .vga_rgb(v_rgb), .vga_hsync(v_ohs), .vga_vsync(v_ovs)
    );

    // 8 x 6 raster: hsync x in [5,6], vsync y in [3,4], visible 4 x 2.
    vga_sync_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .timing_en(en_s), .rgb_in(rgb),
        .pix_x(s_x), .pix_y(s_y), .video_active(s_act),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs),
        .frame_cnt(s_fc), .vga_rgb(s_rgb), .vga_hsync(s_ohs), .vga_vsync(s_ovs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [5:0] pat(input int k);
        return 6'((k * 5 + 3) % 64);
    endfunction

    function automatic logic hs_big(input int x);
        return !(x >= 656 && x <= 751);
    endfunction

    function automatic logic hs_sml(input int x);
        return !(x >= 5 && x <= 6);
    endfunction

    function automatic logic vs_sml(input int y);
        return !(y >= 3 && y <= 4);
    endfunction

    initial begin
        int xd, yd, px, m, pm, xs, ys, xp, yp;
        rst_n = 1'b0;
        en_d  = 1'b1;
        en_v  = 1'b1;
        en_s  = 1'b1;
        rgb   = 6'h3F;
        step(2);
        rst_n = 1'b1;
        step(1000);
        rst_n = 1'b0;
        step(3);

        cur_k = 0;
        check("rst_x",    d_x,   0);
        check("rst_y",    d_y,   0);
        check("rst_fc",   d_fc,  0);
        check("rst_hs",   d_hs,  1);
        check("rst_vs",   d_vs,  1);
        check("rst_act",  d_act, 1);
        check("rst_rgb",  d_rgb, 0);
        check("rst_ohs",  d_ohs, 1);
        check("rst_ovs",  d_ovs, 1);
        check("rst_ls",   d_ls,  0);
        check("rst_fs",   d_fs,  0);
        check("rst_vx",   v_x,   0);
        check("rst_sfc",  s_fc,  0);
        check("rst_sy",   s_y,   0);

        rst_n = 1'b1;
        rgb   = pat(0);
        for (int k = 1; k <= 3200; k++) begin
            step(1);
            cur_k = k;
            xd = k % 800;
            yd = k / 800;
            px = (k - 1) % 800;
            check("d_x",   d_x,   xd);
            check("d_y",   d_y,   yd);
            check("d_act", d_act, xd < 640);
            check("d_hs",  d_hs,  hs_big(xd));
            check("d_vs",  d_vs,  1);
            check("d_ls",  d_ls,  xd == 0);
            check("d_fs",  d_fs,  0);
            check("d_rgb", d_rgb, (px < 640) ? pat(k - 1) : 6'h00);
            check("d_ohs", d_ohs, hs_big(px));

            m = k / 2;
            check("v_x",   v_x,   m % 800);
            check("v_y",   v_y,   m / 800);
            check("v_ls",  v_ls,  (k % 2 == 0) && (m % 800 == 0));
            check("v_hs",  v_hs,  hs_big(m % 800));
            if (m == 0) begin
                check("v_rgb", v_rgb, 0);
                check("v_ohs", v_ohs, 1);
            end else begin
                pm = (m - 1) % 800;
                check("v_rgb", v_rgb, (pm < 640) ? pat(2 * m - 1) : 6'h00);
                check("v_ohs", v_ohs, hs_big(pm));
            end

            xs = k % 8;
            ys = (k / 8) % 6;
            xp = (k - 1) % 8;
            yp = ((k - 1) / 8) % 6;
            check("s_x",   s_x,   xs);
            check("s_y",   s_y,   ys);
            check("s_fc",  s_fc,  k / 48);
            check("s_fs",  s_fs,  k % 48 == 0);
            check("s_ls",  s_ls,  xs == 0);
            check("s_act", s_act, (xs < 4) && (ys < 2));
            check("s_hs",  s_hs,  hs_sml(xs));
            check("s_vs",  s_vs,  vs_sml(ys));
            check("s_rgb", s_rgb, ((xp < 4) && (yp < 2)) ? pat(k - 1) : 6'h00);
            check("s_ovs", s_ovs, vs_sml(yp));
            rgb = pat(k);
        end

        rgb = 6'h3F;
        for (int k = 3201; k <= 49199; k++) begin
            step(1);
            cur_k = k;
            if (k == 49104) begin
                check("fc_1023",  s_fc, 1023);
                check("fs_1023",  s_fs, 1);
            end
            if (k == 49152) begin
                check("fc_wrap",  s_fc, 0);
                check("fs_wrap",  s_fs, 1);
                check("x_wrap",   s_x,  0);
                check("y_wrap",   s_y,  0);
            end
        end

        check("pre_x",   s_x,   7);
        check("pre_y",   s_y,   5);
        check("pre_ohs", s_ohs, 0);
        en_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            cur_k = 50000 + i;
            check("frz_x",   s_x,   7);
            check("frz_y",   s_y,   5);
            check("frz_fc",  s_fc,  0);
            check("frz_fs",  s_fs,  0);
            check("frz_ls",  s_ls,  0);
            check("frz_hs",  s_hs,  1);
            check("frz_vs",  s_vs,  1);
            check("frz_act", s_act, 0);
            check("frz_ohs", s_ohs, 0);
        end
        en_s = 1'b1;
        step(1);
        cur_k = 50010;
        check("ren_x",   s_x,   0);
        check("ren_y",   s_y,   0);
        check("ren_fs",  s_fs,  1);
        check("ren_ls",  s_ls,  1);
        check("ren_fc",  s_fc,  1);
        check("ren_ohs", s_ohs, 1);
        step(1);
        cur_k = 50011;
        check("post_fs", s_fs,  0);
        check("post_x",  s_x,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
